dmem_mmio_responder: RTL and testbench

- Responder for the pipelined CPU's data-memory port.
- Takes the MEM-stage address (ALU result), store data and write strobe.
- Returns read data in the same cycle, with combinational read and clocked write.
- Backs a word RAM, plus a small memory-mapped register window (LED output, cycle counter, store counter, status), so the core can be exercised and observed without a bus fabric.

---
 rtl/dmem_mmio_responder.sv | 167 ++++++++++++++++
 tb/tb_dmem_mmio_responder.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/dmem_mmio_responder.sv
// dmem_mmio_responder
// Data-memory responder for the pipelined core's MEM stage. It provides a word
// RAM with combinational read and clocked write. It also provides a small
// memory-mapped register window: LED at 0x00, CYCLE at 0x04, STATUS at 0x08
// and STORES at 0x0C, offset from MMIO_BASE.
//
// Build option: define DMEM_MMIO_EN to decode the register window. When it is
// left undefined:
//   - the whole address space is aliased RAM;
//   - led is tied to 0;
//   - misalign_err is cleared only by reset;
//   - the CYCLE and STORES counters are not built.
//
// Ports:
//   clk          - clock; all state changes on the rising edge
//   rst          - synchronous active-low reset
//   addr         - byte address from the MEM stage
//   write_data   - store data
//   mem_write    - store strobe
//   read_data    - load data, combinational from addr
//   led          - LED register contents
//   misalign_err - sticky flag, set by a misaligned store
module dmem_mmio_responder #(
  parameter int unsigned DEPTH_WORDS = 64,
  parameter logic [31:0] MMIO_BASE   = 32'hFFFF_FF00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [31:0] write_data,
  input  logic        mem_write,
  output logic [31:0] read_data,
  output logic [7:0]  led,
  output logic        misalign_err
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

  logic [31:0]      ram_q [DEPTH_WORDS];
  logic [IDX_W-1:0] ram_idx;
  logic             mmio_hit;
  logic [7:0]       reg_off;
  logic             store_ok;
  logic             store_bad;
  logic             ram_we;
  logic             status_clr;
  logic [31:0]      mmio_rdata;
  logic             err_q;
  logic             err_d;

  // The upper address bits are ignored on purpose, so RAM wraps.
  assign ram_idx   = addr[IDX_W+1:2];
  assign reg_off   = addr[7:0];
  // During reset, stores are dropped; reset itself clears the flag.
  assign store_ok  = rst & mem_write & (addr[1:0] == 2'b00);
  assign store_bad = rst & mem_write & (addr[1:0] != 2'b00);
  assign ram_we    = store_ok & ~mmio_hit;

`ifdef DMEM_MMIO_EN
  logic [7:0]  led_q;
  logic [7:0]  led_d;
  logic [31:0] cycle_q;
  logic [31:0] cycle_d;
  logic [31:0] stores_q;
  logic [31:0] stores_d;

  assign mmio_hit   = (addr[31:8] == MMIO_BASE[31:8]);
  assign status_clr = store_ok & mmio_hit & (reg_off == 8'h08) & write_data[0];
  assign led        = led_q;

  // Next-state logic for the LED, cycle-counter and store-counter registers.
  always_comb begin
    led_d    = led_q;
    cycle_d  = cycle_q + 32'd1;
    stores_d = stores_q;
    if (!rst) begin
      led_d    = 8'h00;
      cycle_d  = 32'h0000_0000;
      stores_d = 32'h0000_0000;
    end else begin
      if (store_ok && mmio_hit && (reg_off == 8'h00)) begin
        led_d = write_data[7:0];
      end else begin
        led_d = led_q;
      end
      // A store to CYCLE replaces this cycle's increment.
      if (store_ok && mmio_hit && (reg_off == 8'h04)) begin
        cycle_d = write_data;
      end else begin
        cycle_d = cycle_q + 32'd1;
      end
      // Only RAM stores are counted, and the count saturates.
      if (ram_we && (stores_q != 32'hFFFF_FFFF)) begin
        stores_d = stores_q + 32'd1;
      end else begin
        stores_d = stores_q;
      end
    end
  end

  // Register stage for the MMIO registers.
  always_ff @(posedge clk) begin
    led_q    <= led_d;
    cycle_q  <= cycle_d;
    stores_q <= stores_d;
  end

  // Read mux for the register window; unmapped offsets read as zero.
  always_comb begin
    mmio_rdata = 32'h0000_0000;
    case (reg_off)
      8'h00:   mmio_rdata = {24'h00_0000, led_q};
      8'h04:   mmio_rdata = cycle_q;
      8'h08:   mmio_rdata = {31'h0000_0000, err_q};
      8'h0C:   mmio_rdata = stores_q;
      default: mmio_rdata = 32'h0000_0000;
    endcase
  end
`else
  logic unused_addr_bits;

  assign mmio_hit         = 1'b0;
  assign status_clr       = 1'b0;
  assign led              = 8'h00;
  assign mmio_rdata       = 32'h0000_0000;
  assign unused_addr_bits = ^{addr[31:IDX_W+2], MMIO_BASE};
`endif

  // Sticky misalign flag. A set takes priority over a write-1-to-clear.
  always_comb begin
    err_d = err_q;
    if (!rst) begin
      err_d = 1'b0;
    end else if (store_bad) begin
      err_d = 1'b1;
    end else if (status_clr) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q;
    end
  end

  // Register for the misalign flag.
  always_ff @(posedge clk) begin
    err_q <= err_d;
  end

  assign misalign_err = err_q;

  // RAM write port. Contents are not cleared by reset.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      ram_q[ram_idx] <= write_data;
    end
  end

  // Load data selection between the register window and RAM.
  always_comb begin
    read_data = 32'h0000_0000;
    if (mmio_hit) begin
      read_data = mmio_rdata;
    end else begin
      read_data = ram_q[ram_idx];
    end
  end

endmodule

// File: tb/tb_dmem_mmio_responder.sv
// tb_dmem_mmio_responder
// Directed, table-driven bench for dmem_mmio_responder with DEPTH_WORDS = 64.
// Each vector drives the inputs for one cycle. It then checks the outputs
// that are visible before the next rising edge:
//   - read_data is the combinational read;
//   - led and misalign_err are the state left by earlier edges.
// The expectations follow whichever build (DMEM_MMIO_EN or not) is compiled.
module tb_dmem_mmio_responder;

  typedef struct packed {
    logic        rst;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        chk_rd;
    logic [31:0] exp_rd;
    logic        chk_st;
    logic [7:0]  exp_led;
    logic        exp_err;
  } vec_t;

  logic        clk;
  logic        rst;
  logic [31:0] addr;
  logic [31:0] write_data;
  logic        mem_write;
  logic [31:0] read_data;
  logic [7:0]  led;
  logic        misalign_err;

  int n_checks;
  int n_pass;
  vec_t vecs[$];

  dmem_mmio_responder #(
    .DEPTH_WORDS(64),
    .MMIO_BASE  (32'hFFFF_FF00)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .addr        (addr),
    .write_data  (write_data),
    .mem_write   (mem_write),
    .read_data   (read_data),
    .led         (led),
    .misalign_err(misalign_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic r, input logic w, input logic [31:0] a,
                              input logic [31:0] d, input logic cr, input logic [31:0] er,
                              input logic cs, input logic [7:0] el, input logic ee);
    vec_t v;
    v.rst = r; v.we = w; v.addr = a; v.wdata = d;
    v.chk_rd = cr; v.exp_rd = er; v.chk_st = cs; v.exp_led = el; v.exp_err = ee;
    return v;
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic drive(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    rst = r; mem_write = w; addr = a; write_data = d;
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_pass = 0;
    rst = 1'b0; mem_write = 1'b0; addr = 32'h0; write_data = 32'h0;

`ifdef DMEM_MMIO_EN
    vecs.push_back(mk(1'b0, 1'b0, 32'h0000_0000, 32'h0, 1'b0, 32'h0, 1'b0, 8'h00, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 32'hFFFF_FF04, 32'h0, 1'b1, 32'h0000_0000, 1'b1, 8'h00, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 32'hFFFF_FF04, 32'h0, 1'b1, 32'h0000_0001, 1'b1, 8'h00, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 32'hFFFF_FF0C, 32'h0, 1'b1, 32'h0000_0000, 1'b1, 8'h00, 1'b0));
    vecs.push_back(mk(1'b1, 1'b1, 32'h0000_0010, 32'h1111_1111, 1'b0, 32'h0, 1'b1, 8'h00, 1'b0));
    vecs.push_back(mk(1'b1, 1'b1, 32'h0000_0004, 32'h2222_2222, 1'b0, 32'h0, 1'b1, 8'h00, 1'b0));
    vecs.push_back(mk(1'b1, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b1, 32'h1111_1111, 1'b1, 8'h00, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 32'h0000_0010, 32'h0, 1'b1, 32'hDEAD_BEEF, 1'b1, 8'h00, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 32'h0000_0013, 32'h0, 1'b1, 32'hDEAD_BEEF, 1'b1, 8'h00, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 32'hFFFF_FF0C, 32'h0, 1'b1, 32'h0000_0003, 1'b1, 8'h00, 1'b0));
    vecs.push_back(mk(1'b1, 1'b1, 32'h0000_0100, 32'h0000_1234, 1'b0, 32'h0, 1'b1, 8'h00, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 32'h0000_0000, 32'h0, 1'b1, 32'h0000_1234, 1'b1, 8'h00, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 32'h0000_0110, 32'h0, 1'b1, 32'hDEAD_BEEF, 1'b1, 8'h00, 1'b0));
    vecs.push_back(mk(1'b1, 1'b1, 32'hFFFF_FF00, 32'hFFFF_FFA5, 1'b1, 32'h0000_0000, 1'b1, 8'h00, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 32'hFFFF_FF00, 32'h0, 1'b1, 32'h0000_00A5, 1'b1, 8'hA5, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 32'hFFFF_FF0C, 32'h0, 1'b1, 32'h0000_0004, 1'b1, 8'hA5, 1'b0));
    vecs.push_back(mk(1'b1, 1'b1, 32'h0000_0006, 32'h0000_0099, 1'b1, 32'h2222_2222, 1'b1, 8'hA5, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 32'h0000_0004, 32'h0, 1'b1, 32'h2222_2222, 1'b1, 8'hA5, 1'b1));
    vecs.push_back(mk(1'b1, 1'b0, 32'hFFFF_FF08, 32'h0, 1'b1, 32'h0000_0001, 1'b1, 8'hA5, 1'b1));
    vecs.push_back(mk(1'b1, 1'b0, 32'hFFFF_FF0C, 32'h0, 1'b1, 32'h0000_0004, 1'b1, 8'hA5, 1'b1));
    vecs.push_back(mk(1'b1, 1'b1, 32'hFFFF_FF08, 32'h0000_0001, 1'b1, 32'h0000_0001, 1'b1, 8'hA5, 1'b1));
    vecs.push_back(mk(1'b1, 1'b0, 32'hFFFF_FF08, 32'h0, 1'b1, 32'h0000_0000, 1'b1, 8'hA5, 1'b0));
    // A misaligned write-1-to-clear: the set wins and nothing is cleared.
    vecs.push_back(mk(1'b1, 1'b1, 32'hFFFF_FF09, 32'h0000_0001, 1'b1, 32'h0000_0000, 1'b1, 8'hA5, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 32'hFFFF_FF08, 32'h0, 1'b1, 32'h0000_0001, 1'b1, 8'hA5, 1'b1));
    vecs.push_back(mk(1'b1, 1'b1, 32'hFFFF_FF10, 32'h0000_0005, 1'b1, 32'h0000_0000, 1'b1, 8'hA5, 1'b1));
    vecs.push_back(mk(1'b1, 1'b0, 32'hFFFF_FF10, 32'h0, 1'b1, 32'h0000_0000, 1'b1, 8'hA5, 1'b1));
    vecs.push_back(mk(1'b1, 1'b1, 32'hFFFF_FF0C, 32'h0000_0007, 1'b1, 32'h0000_0004, 1'b1, 8'hA5, 1'b1));
    vecs.push_back(mk(1'b1, 1'b0, 32'hFFFF_FF0C, 32'h0, 1'b1, 32'h0000_0004, 1'b1, 8'hA5, 1'b1));
    vecs.push_back(mk(1'b1, 1'b1, 32'hFFFF_FF04, 32'hFFFF_FFFE, 1'b1, 32'h0000_001B, 1'b1, 8'hA5, 1'b1));
    vecs.push_back(mk(1'b1, 1'b0, 32'hFFFF_FF04, 32'h0, 1'b1, 32'hFFFF_FFFE, 1'b1, 8'hA5, 1'b1));
    vecs.push_back(mk(1'b1, 1'b0, 32'hFFFF_FF04, 32'h0, 1'b1, 32'hFFFF_FFFF, 1'b1, 8'hA5, 1'b1));
    vecs.push_back(mk(1'b1, 1'b0, 32'hFFFF_FF04, 32'h0, 1'b1, 32'h0000_0000, 1'b1, 8'hA5, 1'b1));
    vecs.push_back(mk(1'b0, 1'b1, 32'h0000_0010, 32'h0000_0BAD, 1'b1, 32'hDEAD_BEEF, 1'b1, 8'hA5, 1'b1));
    vecs.push_back(mk(1'b1, 1'b0, 32'hFFFF_FF04, 32'h0, 1'b1, 32'h0000_0000, 1'b1, 8'h00, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 32'hFFFF_FF04, 32'h0, 1'b1, 32'h0000_0001, 1'b1, 8'h00, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 32'hFFFF_FF0C, 32'h0, 1'b1, 32'h0000_0000, 1'b1, 8'h00, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 32'h0000_0010, 32'h0, 1'b1, 32'hDEAD_BEEF, 1'b1, 8'h00, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 32'h0000_0004, 32'h0, 1'b1, 32'h2222_2222, 1'b1, 8'h00, 1'b0));
`else
    vecs.push_back(mk(1'b0, 1'b0, 32'h0000_0000, 32'h0, 1'b0, 32'h0, 1'b0, 8'h00, 1'b0));
    vecs.push_back(mk(1'b1, 1'b1, 32'h0000_0000, 32'h0000_0055, 1'b0, 32'h0, 1'b1, 8'h00, 1'b0));
    vecs.push_back(mk(1'b1, 1'b1, 32'hFFFF_FF00, 32'h0000_0077, 1'b1, 32'h0000_0055, 1'b1, 8'h00, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 32'h0000_0000, 32'h0, 1'b1, 32'h0000_0077, 1'b1, 8'h00, 1'b0));
    vecs.push_back(mk(1'b1, 1'b1, 32'h0000_0004, 32'h0000_0022, 1'b0, 32'h0, 1'b1, 8'h00, 1'b0));
    vecs.push_back(mk(1'b1, 1'b1, 32'h0000_0006, 32'h0000_0099, 1'b1, 32'h0000_0022, 1'b1, 8'h00, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 32'h0000_0004, 32'h0, 1'b1, 32'h0000_0022, 1'b1, 8'h00, 1'b1));
    vecs.push_back(mk(1'b1, 1'b1, 32'hFFFF_FF08, 32'h0000_0001, 1'b0, 32'h0, 1'b1, 8'h00, 1'b1));
    vecs.push_back(mk(1'b1, 1'b0, 32'h0000_0008, 32'h0, 1'b1, 32'h0000_0001, 1'b1, 8'h00, 1'b1));
    vecs.push_back(mk(1'b0, 1'b1, 32'h0000_0000, 32'h0000_0BAD, 1'b1, 32'h0000_0077, 1'b1, 8'h00, 1'b1));
    vecs.push_back(mk(1'b1, 1'b0, 32'h0000_0000, 32'h0, 1'b1, 32'h0000_0077, 1'b1, 8'h00, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 32'h0000_0100, 32'h0, 1'b1, 32'h0000_0077, 1'b1, 8'h00, 1'b0));
`endif

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].we, vecs[i].addr, vecs[i].wdata);
      if (vecs[i].chk_rd) check32($sformatf("vec%0d read_data", i), read_data, vecs[i].exp_rd);
      if (vecs[i].chk_st) begin
        check32($sformatf("vec%0d led", i), {24'h0, led}, {24'h0, vecs[i].exp_led});
        check32($sformatf("vec%0d misalign_err", i), {31'h0, misalign_err}, {31'h0, vecs[i].exp_err});
      end
    end

`ifdef DMEM_MMIO_EN
    // Multi-cycle reset: CYCLE holds 0 while reset is held, then counts up.
    drive(1'b0, 1'b0, 32'hFFFF_FF04, 32'h0);
    for (int k = 0; k < 2; k++) begin
      drive(1'b0, 1'b0, 32'hFFFF_FF04, 32'h0);
      check32($sformatf("cycle_in_reset%0d", k), read_data, 32'h0000_0000);
    end
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 1'b0, 32'hFFFF_FF04, 32'h0);
      check32($sformatf("cycle_after_reset%0d", k), read_data, k);
    end
`else
    // Aliasing: one store is visible through several addresses that wrap.
    drive(1'b1, 1'b1, 32'h0000_0208, 32'h0000_00A0);
    drive(1'b1, 1'b0, 32'h0000_0008, 32'h0);
    check32("alias_0x008", read_data, 32'h0000_00A0);
    drive(1'b1, 1'b0, 32'h0000_0108, 32'h0);
    check32("alias_0x108", read_data, 32'h0000_00A0);
    drive(1'b1, 1'b0, 32'hFFFF_FE0A, 32'h0);
    check32("alias_high_misaligned_read", read_data, 32'h0000_00A0);
    check32("no_error_on_misaligned_read", {31'h0, misalign_err}, 32'h0000_0000);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
